wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter that shares the SPI SRAM controller between the SPI host bridge (m0) and the levenshtein controller master port (m1).
- Grants by round-robin and holds the grant for the whole cyc burst.
- Muxes request and response signals for the granted master only.
- Includes a watchdog that aborts a hung slave cycle with an error.

Parameters:
ADDR_WIDTH, 22, address width of both masters and the slave
DATA_WIDTH, 8, data bus width
TIMEOUT, 255, max cycles stb may wait for a termination before abort; 0 disables watchdog

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_adr_i  in  ADDR_WIDTH  master 0 address
m0_we_i  in  1  master 0 write enable
m0_dat_i  in  DATA_WIDTH  master 0 write data
m0_ack_o  out  1  master 0 ack
m0_err_o  out  1  master 0 error
m0_rty_o  out  1  master 0 retry
m0_dat_o  out  DATA_WIDTH  master 0 read data
m1_cyc_i, m1_stb_i, m1_adr_i, m1_we_i, m1_dat_i, m1_ack_o, m1_err_o, m1_rty_o, m1_dat_o  as m0_*, for master 1
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_adr_o  out  ADDR_WIDTH  slave address
s_we_o  out  1  slave write enable
s_dat_o  out  DATA_WIDTH  slave write data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
s_rty_i  in  1  slave retry
s_dat_i  in  DATA_WIDTH  slave read data

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT. State is registered; all mux selects derive from the registered state only.
- Reset (rst_i=1 at clk_i edge):
  - State goes to IDLE and the round-robin pointer favours m0.
  - The watchdog counter clears.
  - All s_* control outputs (cyc, stb, we) and all m*_ack/err/rty outputs are 0.
  - Reset mid-transfer drops s_cyc_o the cycle after the edge; no termination is forwarded.
- IDLE:
  - One cyc request: go to the matching GNTx next cycle.
  - Both cyc requests: grant the master the pointer favours.
  - Grant latency is 1 cycle from cyc assertion to s_cyc_o.
- GNTx, slave side:
  - s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i.
  - s_adr_o, s_we_o and s_dat_o come from mx, combinationally.
- GNTx, master side:
  - mx_ack_o, mx_err_o, mx_rty_o and mx_dat_o pass through from the slave.
  - The non-granted master sees ack/err/rty = 0 and dat = 0; its request is held pending.
- Grant release:
  - When mx_cyc_i=0 in GNTx, the pointer moves to favour the other master.
  - The next state is GNT(other) if that master's cyc is high, otherwise IDLE.
  - There is no idle gap on handover; s_cyc_o drops for at least the release cycle because mx_cyc_i is 0.
- Locking: the grant is never preempted while mx_cyc_i=1, including across multiple stb phases.
- IDLE and ABORT: s_cyc_o=s_stb_o=0 and s_we_o=0. s_adr_o and s_dat_o are don't-care but driven from m0.
- Watchdog (TIMEOUT>0):
  - The counter increments each cycle in GNTx with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - It clears on any termination, on stb low, or on leaving GNTx.
  - When the counter equals TIMEOUT with no termination in that cycle, the arbiter pulses mx_err_o for exactly 1 cycle (the following cycle) and enters ABORT.
- ABORT:
  - The slave is driven idle; no termination from the slave is forwarded.
  - Stay in ABORT until mx_cyc_i=0, then apply the release rule above.
- Simultaneous events:
  - A termination in the same cycle the counter hits TIMEOUT wins; no abort occurs.
  - Both masters asserting cyc in the same cycle as a release resolves per the pointer.
- Counter width: clog2(TIMEOUT+1), saturating.
- Combinational paths exist from s_ack_i/s_err_i/s_rty_i/s_dat_i to the granted master's outputs, and from the granted master's request signals to s_*. Zero added latency once granted.

Test Plan:
- Single master: m1 cyc/stb read at adr 0x000123, slave acks 3 cycles later with 0x5A -> s_cyc_o high 1 cycle after m1_cyc_i; m1_ack_o=1 with m1_dat_o=0x5A in the same cycle as s_ack_i; m0_ack_o stays 0.
- Contention from reset: m0 and m1 assert cyc in the same cycle -> m0 granted first; on m0 cyc drop, m1 is granted with no IDLE cycle. Next simultaneous request after both finish -> m1 loses, m0 wins because the pointer alternates.
- Burst lock: m0 performs 4 back-to-back writes (0x11..0x14) under one cyc while m1 requests throughout -> all 4 reach the slave in order; m1 is granted only after m0_cyc_i falls.
- Watchdog: TIMEOUT=4, m1 stb held, slave never responds -> m1_err_o pulses once, 5 cycles after s_stb_o rises, then s_cyc_o=0. A late s_ack_i is not forwarded. After m1_cyc_i drops, m0 is served normally.
- Ack at the limit: TIMEOUT=4, s_ack_i arrives exactly on the cycle the counter reaches 4 -> normal ack, no err, no ABORT.
- Reset mid-transfer: rst_i asserted while in GNT0 with stb high -> next cycle s_cyc_o=0 and all m*_ack/err/rty=0; after reset, the pointer favours m0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant, cyc-burst locking
// and a watchdog that aborts a hung slave cycle with an error to the granted master.
module wb_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic                  m0_we_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic                  m1_we_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic                  s_we_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StAbort} state_e;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;    // 0: m0 favoured, 1: m1 favoured
  logic            owner_q, owner_d;  // master whose cycle was aborted
  logic            err_q, err_d;      // one-cycle abort error pulse
  logic [CntW-1:0] cnt_q, cnt_d;

  logic in_gnt;
  logic cur_m;
  logic cur_cyc;
  logic cur_stb;
  logic other_cyc;
  logic term;
  logic wd_hit;

  assign in_gnt    = (state_q == StGnt0) || (state_q == StGnt1);
  // In ABORT the owner is the master holding the bus; otherwise it follows the grant state.
  assign cur_m     = (state_q == StAbort) ? owner_q : (state_q == StGnt1);
  assign cur_cyc   = cur_m ? m1_cyc_i : m0_cyc_i;
  assign cur_stb   = cur_m ? m1_stb_i : m0_stb_i;
  assign other_cyc = cur_m ? m0_cyc_i : m1_cyc_i;
  assign term      = s_ack_i | s_err_i | s_rty_i;
  assign wd_hit    = (TIMEOUT > 0) && in_gnt && cur_stb && !term && (cnt_q == CntLimit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    err_d   = 1'b0;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && (!m1_cyc_i || !prio_q)) begin
          state_d = StGnt0;
        end else if (m1_cyc_i) begin
          state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (!cur_cyc) begin
          prio_d  = ~cur_m;
          state_d = other_cyc ? (cur_m ? StGnt0 : StGnt1) : StIdle;
        end else if (wd_hit) begin
          state_d = StAbort;
          owner_d = cur_m;
          err_d   = 1'b1;
        end else if ((TIMEOUT > 0) && cur_stb && !term) begin
          cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StAbort: begin
        if (!cur_cyc) begin
          prio_d  = ~cur_m;
          state_d = other_cyc ? (cur_m ? StGnt0 : StGnt1) : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      StGnt0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        m0_rty_o = s_rty_i;
        m0_dat_o = s_dat_i;
      end
      StGnt1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_adr_o  = m1_adr_i;
        s_we_o   = m1_we_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        m1_rty_o = s_rty_i;
        m1_dat_o = s_dat_i;
      end
      StAbort: begin
        m0_err_o = err_q & ~owner_q;
        m1_err_o = err_q & owner_q;
      end
      default: ;
    endcase
  end

endmodule
